// File: rtl/snn_pkg.sv
// Shared types and helpers for the layer-2 spiking neuron sequencer.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SPIKE_N  = 5;
    localparam int WEIGHT_W = 8;

    // Signed add clamped to the range of a w-bit two's-complement value.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 w
    );
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = 33'(a) + 33'(b);
        hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (w - 1));
        if (sum > hi) begin
            return hi[31:0];
        end else if (sum < lo) begin
            return lo[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/snn_neuron_update.sv
// Combinational membrane update shared by all layer-2 neurons.
// Optional leak path enabled by defining SNN_LEAK_EN.
module snn_neuron_update
    import snn_pkg::*;
#(
    parameter int POT_W      = 12,
    parameter int THRESH     = 64,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [POT_W-1:0]    v,
    input  logic signed [WEIGHT_W-1:0] s,
    output logic signed [POT_W-1:0]    v_next,
    output logic                       fire
);

    logic signed [POT_W-1:0] base;
    logic signed [31:0]      sum_sat;

`ifdef SNN_LEAK_EN
    // v - v/2^k never leaves the POT_W range, so no saturation is needed here.
    assign base = v - (v >>> LEAK_SHIFT);
`else
    localparam int unused_leak_shift = LEAK_SHIFT;
    assign base = v;
`endif

    assign sum_sat = sat_add(32'(base), 32'(s), POT_W);
    assign fire    = (sum_sat >= THRESH);
    assign v_next  = fire ? '0 : sum_sat[POT_W-1:0];

endmodule

// File: rtl/snn_layer2_sched.sv
// Layer-2 sequencer: shares one external MAC across N_OUT integrate-and-fire neurons.
// Build option: SNN_LEAK_EN adds a per-timestep membrane leak.
module snn_layer2_sched
    import snn_pkg::*;
#(
    parameter int  N_OUT      = 10,
    parameter int  POT_W      = 12,
    parameter int  THRESH     = 64,
    parameter int  LEAK_SHIFT = 3,
    localparam int IDX_W      = $clog2(N_OUT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          clear_pot,
    input  logic [SPIKE_N-1:0]            spikes_in,
    output logic                          busy,
    output logic                          done,
    output logic [N_OUT-1:0]              spikes_out,
    output logic                          w_rd_en,
    output logic [IDX_W-1:0]              w_addr,
    input  logic [SPIKE_N*WEIGHT_W-1:0]   w_data,
    output logic [SPIKE_N-1:0]            mac_pixels,
    output logic [SPIKE_N*WEIGHT_W-1:0]   mac_weights,
    input  logic [WEIGHT_W-1:0]           mac_sum
);

    state_t                  state_reg;
    state_t                  state_next;
    logic [IDX_W-1:0]        idx_reg;
    logic [SPIKE_N-1:0]      spikes_reg;
    logic signed [POT_W-1:0] pot_reg [N_OUT];
    logic                    fire_reg [N_OUT];

    logic                    last_idx;
    logic                    do_clear;
    logic                    acc_en;
    logic signed [POT_W-1:0] cur_pot;
    logic signed [POT_W-1:0] upd_pot;
    logic                    upd_fire;

    assign last_idx = (idx_reg == IDX_W'(N_OUT - 1));
    assign do_clear = (state_reg == IDLE) && clear_pot;
    assign acc_en   = (state_reg == ACC);
    assign cur_pot  = pot_reg[idx_reg];

    always_comb begin
        state_next  = state_reg;
        busy        = 1'b0;
        done        = 1'b0;
        w_rd_en     = 1'b0;
        w_addr      = '0;
        mac_pixels  = '0;
        mac_weights = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                busy       = 1'b1;
                w_rd_en    = 1'b1;
                w_addr     = idx_reg;
                state_next = ACC;
            end
            ACC: begin
                busy        = 1'b1;
                mac_weights = w_data;
                mac_pixels  = spikes_reg;
                state_next  = last_idx ? DONE : READ;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            spikes_reg <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && start) begin
                idx_reg    <= '0;
                spikes_reg <= spikes_in;
            end else if (acc_en && !last_idx) begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    snn_neuron_update #(
        .POT_W      (POT_W),
        .THRESH     (THRESH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_update (
        .v      (cur_pot),
        .s      (mac_sum),
        .v_next (upd_pot),
        .fire   (upd_fire)
    );

    // Each neuron owns its potential and spike bit; only the indexed one updates in ACC.
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_neuron
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pot_reg[gi]  <= '0;
                fire_reg[gi] <= 1'b0;
            end else if (do_clear) begin
                pot_reg[gi] <= '0;
            end else if (acc_en && (idx_reg == IDX_W'(gi))) begin
                pot_reg[gi]  <= upd_pot;
                fire_reg[gi] <= upd_fire;
            end
        end
        assign spikes_out[gi] = fire_reg[gi];
    end

endmodule

// File: tb/tb_snn_layer2_sched.sv
// Bench for snn_layer2_sched: ROM and MAC models, per-timestep scoreboard, corner sequences.
module tb_snn_layer2_sched;

    localparam int N_OUT  = 10;
    localparam int POT_W  = 12;
    localparam int THRESH = 64;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clear_pot;
    logic [4:0]  spikes_in;
    logic        busy;
    logic        done;
    logic [9:0]  spikes_out;
    logic        w_rd_en;
    logic [3:0]  w_addr;
    logic [39:0] w_data;
    logic [4:0]  mac_pixels;
    logic [39:0] mac_weights;
    logic [7:0]  mac_sum;

    logic [39:0] rom [N_OUT];
    int          pm  [N_OUT];

    typedef struct packed {
        logic [N_OUT-1:0]       sp;
        logic [N_OUT*POT_W-1:0] pots;
    } exp_t;
    exp_t sb [$];

    typedef struct {
        bit         clr;
        logic [4:0] sp;
        logic [9:0] exp_so;
        int         exp_pot;
    } vec_t;
    vec_t tbl [10];

    int total = 0;
    int bad   = 0;
    int ts_no = 0;

    snn_layer2_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .clear_pot   (clear_pot),
        .spikes_in   (spikes_in),
        .busy        (busy),
        .done        (done),
        .spikes_out  (spikes_out),
        .w_rd_en     (w_rd_en),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .mac_pixels  (mac_pixels),
        .mac_weights (mac_weights),
        .mac_sum     (mac_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd_en) w_data <= rom[w_addr];
    end

    logic [7:0] mac_acc;
    always_comb begin
        mac_acc = 8'd0;
        for (int k = 0; k < 5; k++) begin
            if (mac_pixels[k]) mac_acc = mac_acc + mac_weights[8*k +: 8];
        end
    end
    assign mac_sum = mac_acc;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_ts(input bit clr, input logic [4:0] sp);
        exp_t       e;
        logic [7:0] s8;
        int         v;
        if (clr) begin
            for (int i = 0; i < N_OUT; i++) pm[i] = 0;
        end
        for (int i = 0; i < N_OUT; i++) begin
            s8 = 8'd0;
            for (int k = 0; k < 5; k++) begin
                if (sp[k]) s8 = s8 + rom[i][8*k +: 8];
            end
            v = pm[i];
`ifdef SNN_LEAK_EN
            v = v - (v >>> 3);
`endif
            v = v + int'($signed(s8));
            if (v > 2047) v = 2047;
            if (v < -2048) v = -2048;
            e.sp[i] = (v >= THRESH);
            if (v >= THRESH) v = 0;
            pm[i] = v;
            e.pots[POT_W*i +: POT_W] = v[POT_W-1:0];
        end
        sb.push_back(e);
    endtask

    task automatic run_ts(input bit clr, input logic [4:0] sp, input int inj_c,
                          input bit inj_s, input bit inj_cl, input int tail);
        int   ndone;
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        clear_pot = clr;
        spikes_in = sp;
        model_ts(clr, sp);
        ndone = 0;
        for (int c = 1; c <= 21 + tail; c++) begin
            @(negedge clk);
            start     = 1'b0;
            clear_pot = 1'b0;
            spikes_in = ~sp;
            chk("busy", busy, (c <= 20));
            chk("done", done, (c == 21));
            chk("w_rd_en", w_rd_en, ((c % 2 == 1) && (c <= 19)));
            if ((c % 2 == 1) && (c <= 19)) chk("w_addr", w_addr, (c - 1) / 2);
            if ((c % 2 == 0) && (c <= 20)) begin
                chk("mac_pixels", mac_pixels, sp);
                chk("mac_weights", mac_weights, rom[(c - 2) / 2]);
            end else begin
                chk("mac_pixels_idle", mac_pixels, 0);
                chk("mac_weights_idle", mac_weights, 0);
            end
            if (done) begin
                ndone++;
                chk("sb_nonempty", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("spikes_out", spikes_out, e.sp);
                    for (int i = 0; i < N_OUT; i++)
                        chk($sformatf("pot%0d", i), dut.pot_reg[i], $signed(e.pots[POT_W*i +: POT_W]));
                    $display("ts %0d: cycle=%0d spikes_out=%h pot0=%0d pot3=%0d",
                             ts_no, c, spikes_out, dut.pot_reg[0], dut.pot_reg[3]);
                    ts_no++;
                end
            end
            if (c == inj_c) begin
                start     = inj_s;
                clear_pot = inj_cl;
            end
        end
        chk("done_count", ndone, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_spikes_out"}, spikes_out, 0);
        chk({tag, "_w_rd_en"}, w_rd_en, 0);
        chk({tag, "_w_addr"}, w_addr, 0);
        chk({tag, "_mac_pixels"}, mac_pixels, 0);
        chk({tag, "_mac_weights"}, mac_weights, 0);
        for (int i = 0; i < N_OUT; i++) chk($sformatf("%s_pot%0d", tag, i), dut.pot_reg[i], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 5'b00001, 10'h000, 16};
        tbl[1] = '{1'b0, 5'b00001, 10'h000, 32};
        tbl[2] = '{1'b0, 5'b00001, 10'h000, 48};
        tbl[3] = '{1'b0, 5'b00001, 10'h3FF, 0};
        tbl[4] = '{1'b0, 5'b00001, 10'h000, 16};
        tbl[5] = '{1'b0, 5'b00011, 10'h000, 48};
        tbl[6] = '{1'b0, 5'b00000, 10'h000, 48};
        tbl[7] = '{1'b0, 5'b00111, 10'h3FF, 0};
        tbl[8] = '{1'b0, 5'b11111, 10'h3FF, 0};
        tbl[9] = '{1'b1, 5'b00000, 10'h000, 0};

        for (int i = 0; i < N_OUT; i++) begin
            rom[i] = {5{8'h10}};
            pm[i]  = 0;
        end
        rst_n     = 1'b0;
        start     = 1'b0;
        clear_pot = 1'b0;
        spikes_in = 5'd0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Back-to-back timesteps driven from the table.
        for (int t = 0; t < 10; t++) begin
            run_ts(tbl[t].clr, tbl[t].sp, -1, 1'b0, 1'b0, 0);
`ifndef SNN_LEAK_EN
            chk($sformatf("tbl%0d_spikes", t), spikes_out, tbl[t].exp_so);
            for (int i = 0; i < N_OUT; i++)
                chk($sformatf("tbl%0d_pot%0d", t, i), dut.pot_reg[i], tbl[t].exp_pot);
`endif
        end

        // Clear and start in the same cycle: neuron 3 restarts from zero.
        repeat (3) run_ts(1'b0, 5'b00001, -1, 1'b0, 1'b0, 0);
`ifndef SNN_LEAK_EN
        chk("pre_clear_pot3", dut.pot_reg[3], 48);
`endif
        run_ts(1'b1, 5'b00001, -1, 1'b0, 1'b0, 0);
        chk("clear_start_pot3", dut.pot_reg[3], 16);
        chk("clear_start_spike3", spikes_out[3], 0);

        // start / clear_pot pulsed while busy are ignored.
        run_ts(1'b0, 5'b00001, 5, 1'b1, 1'b0, 3);
        run_ts(1'b0, 5'b00001, 5, 1'b0, 1'b1, 3);
`ifndef SNN_LEAK_EN
        chk("ignored_pot0", dut.pot_reg[0], 48);
`endif

        // Asynchronous reset in the middle of a timestep.
        @(negedge clk);
        start     = 1'b1;
        spikes_in = 5'b00001;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (2) begin
            @(negedge clk);
            chk("midreset_hold_done", done, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < N_OUT; i++) pm[i] = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_busy", busy, 0);
            chk("post_reset_done", done, 0);
        end
        run_ts(1'b0, 5'b00001, -1, 1'b0, 1'b0, 0);
        chk("post_reset_pot9", dut.pot_reg[9], 16);

        // Wrapped MAC sum (-128) drives neuron 0 to the negative rail.
        rom[0] = {5{8'h80}};
        for (int st = 0; st < 60; st++)
            run_ts(st == 0, 5'b11111, -1, 1'b0, 1'b0, 0);
`ifndef SNN_LEAK_EN
        chk("sat_pot0", dut.pot_reg[0], -2048);
`endif
        chk("sat_spikes", spikes_out, 10'h3FE);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snn_layer2_sched.md
# snn_layer2_sched

Sequencer for the layer-2 spiking neurons. Time-multiplexes one shared `mac_layer2` (5 spike inputs × 5 signed 8-bit weights) across `N_OUT` output neurons per timestep. For each neuron it:

- fetches the neuron's 40-bit weight row from a synchronous weight ROM;
- drives the MAC with the captured spike vector;
- integrates the MAC sum into a per-neuron membrane potential;
- fires and resets on threshold.

It sits between the layer-1 spike output and the classifier/spike counter.

## Interface
- `N_OUT`, 10: number of layer-2 neurons; minimum 2.
- `POT_W`, 12: membrane potential width, signed.
- `THRESH`, 64: firing threshold, signed, fits `POT_W`.
- `LEAK_SHIFT`, 3: leak divisor exponent. Used only with `SNN_LEAK_EN`.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to process one timestep. Sampled only in IDLE.
- `clear_pot`  in  1  zero all potentials. Sampled only in IDLE.
- `spikes_in`  in  5  layer-1 spike vector. Captured on accepted `start`.
- `busy`  out  1  high from the cycle after `start` until DONE.
- `done`  out  1  one-cycle pulse; `spikes_out` is valid.
- `spikes_out`  out  N_OUT  registered output spikes of the last timestep.
- `w_rd_en`  out  1  weight ROM read enable.
- `w_addr`  out  clog2(N_OUT)  weight row index (= neuron index).
- `w_data`  in  40  weight row; valid one cycle after `w_rd_en`. Bits [8k+7:8k] pair with spike k.
- `mac_pixels`  out  5  to MAC `pixels`.
- `mac_weights`  out  40  to MAC `weights`.
- `mac_sum`  in  8  MAC `sumOut` (combinational).

## Operation
- **FSM states:** IDLE, READ, ACC, DONE.
- **IDLE**
  - If `clear_pot`: all potentials are set to 0.
  - If `start`: capture `spikes_in`, set idx=0, go to READ.
  - If both are asserted in the same cycle, the clear takes effect first, so the timestep starts from zero potentials.
- **READ:** `w_rd_en`=1, `w_addr`=idx, then go to ACC.
- **ACC**
  - `mac_weights`=`w_data` and `mac_pixels`=captured spikes. Both are driven to 0 outside ACC.
  - Update potential[idx] per the arithmetic below.
  - If idx==N_OUT-1, go to DONE; else idx+1 and go to READ.
- **DONE:** `done`=1, then go to IDLE.
- **Arithmetic**
  - s = `mac_sum` as signed 8-bit; the MAC's wrap-around is accepted.
  - v' = v + sext(s), saturating at the POT_W signed limits.
  - If v' ≥ THRESH: spikes_out[idx]=1 and v=0. Otherwise spikes_out[idx]=0 and v=v'.
- **Ignored inputs:** `start` and `clear_pot` have no effect outside IDLE.
- **Reset mid-timestep:** all state is cleared immediately. No `done` pulse is issued for the aborted timestep.

## Timing
- **Reset values:** FSM=IDLE, idx=0, all potentials=0, `spikes_out`=0, `busy`=0, `done`=0, `w_rd_en`=0, `w_addr`=0, `mac_pixels`=0, `mac_weights`=0.
- **Per-neuron cost:** 2 cycles (READ, ACC).
- **Latency:** `start` at cycle 0 → `done` at cycle 2·N_OUT+1 (21 with defaults).
- **Back-to-back:** the next `start` is accepted in the cycle after `done`, so throughput is one timestep per 2·N_OUT+2 cycles.
- **`spikes_out`:** bits update individually in their ACC cycle. The full vector is coherent only on and after `done`, and is held until the next accepted `start`.
- **`busy`:** deasserts in the same cycle `done` is high.

## Configuration
- **`SNN_LEAK_EN` defined:** in ACC, v' = v − (v >>> LEAK_SHIFT) + sext(s), arithmetic shift, saturating as above. The leak is applied once per neuron per timestep.
- **`SNN_LEAK_EN` undefined:** pure integrate-and-fire; the `LEAK_SHIFT` parameter is unused.

## Structure
- **Package `snn_pkg`:**
  - FSM state enum (IDLE/READ/ACC/DONE);
  - constants `SPIKE_N`=5 and `WEIGHT_W`=8;
  - a signed saturating-add function parameterised by POT_W.
- **Sub-module `snn_neuron_update`:** combinational. Takes (v, s) and produces (v_next, fire), with the leak path under `SNN_LEAK_EN`. It is instanced once and shared across all neurons.
- **Top level:** potentials are a register array indexed by idx. `mac_layer2` is instanced at the layer top, not inside this block.

## Test plan
- **Latency and protocol:** reset, then `start` with `spikes_in`=5'b00001 and ROM rows all 8'h10. Expect `w_addr` to step 0..9 in READ cycles only, `done` at cycle 21, all potentials=16, `spikes_out`=0.
- **Firing:** repeat the previous timestep 4 times (potential 64). Expect the 4th `done` to show `spikes_out`=10'h3FF and potentials=0; the 5th timestep gives `spikes_out`=0 and potential=16.
- **Signed saturation and wrap:** row 0 = five × 8'h80, `spikes_in`=5'b11111. MAC sum wraps to 8'h80 (−128); ×20 timesteps potential[0] saturates at −2048 with no wrap. The leak-enabled build holds a stable negative value.
- **Clear and start together:** with potential[3]=48, assert `clear_pot` and `start` in the same IDLE cycle with s=+16 for neuron 3. Expect potential[3]=16, not 64, and spikes_out[3]=0.
- **Ignored inputs while busy:** `start` or `clear_pot` pulsed at cycle 5 of a timestep has no effect; exactly one `done` is issued.
- **Async reset mid-timestep:** drop `rst_n` at cycle 7. Expect all outputs to be at reset values immediately and no `done`. A fresh `start` then completes in 21 cycles.
